game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 26 ++
 rtl/game_sequencer.sv | 120 ++++++++++++
 tb/tb_game_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Game sequencer interface: game-step inputs and sequencer strobes/status.
// The bench/system side uses the master modport and the sequencer uses the slave modport.
interface game_sequencer_if;
  logic       TICK;
  logic       START;
  logic       PAUSE;
  logic [3:0] NOTE_BOTTOM;
  logic [3:0] KEY_N;
  logic [6:0] RAM_ADDR;
  logic       LOAD;
  logic       SHIFT_EN;
  logic       SCORE_INC;
  logic       SCORE_CLR;
  logic       GAME_OVER;
  logic [2:0] STATE;

  modport master (
    output TICK, START, PAUSE, NOTE_BOTTOM, KEY_N,
    input  RAM_ADDR, LOAD, SHIFT_EN, SCORE_INC, SCORE_CLR, GAME_OVER, STATE
  );

  modport slave (
    input  TICK, START, PAUSE, NOTE_BOTTOM, KEY_N,
    output RAM_ADDR, LOAD, SHIFT_EN, SCORE_INC, SCORE_CLR, GAME_OVER, STATE
  );
endinterface

// File: rtl/game_sequencer.sv
// Rhythm-game sequencer: countdown, play with 4-tick pattern loads,
// pause, drain of the shifter rows, and per-tick note judging.
// Optional build macro GH_LOOP_TRACK_EN: the track loops back to
// address 0 after its last pattern instead of draining to DONE.
module game_sequencer (
  input  logic            CLK,
  input  logic            RESET_N,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e     state_q;
  logic [6:0] addr_q;
  logic [1:0] phase_q;
  logic [2:0] tick_cnt_q;
  logic       score_inc_q;
  logic       score_clr_q;

  logic       judge_tick;
  logic [3:0] lane_wrong;
  logic       score_inc_d;
  logic       score_clr_d;
  logic       load;
`ifndef GH_LOOP_TRACK_EN
  logic       track_end;
`endif

  // Tick qualification, lane judging and strobe decode for the current cycle.
  always_comb begin
    judge_tick  = bus.TICK && ((state_q == S_PLAY) || (state_q == S_DRAIN));
    lane_wrong  = (~bus.KEY_N) ^ bus.NOTE_BOTTOM;
    score_inc_d = judge_tick && (lane_wrong == 4'd0) && (bus.NOTE_BOTTOM != 4'd0);
    score_clr_d = judge_tick && (lane_wrong != 4'd0);
    load        = bus.TICK && (state_q == S_PLAY) && (phase_q == 2'd3);
`ifndef GH_LOOP_TRACK_EN
    track_end   = load && (addr_q == 7'd127);
`endif
  end

  // Game FSM with phase, address, tick counter and registered score pulses.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= '0;
      tick_cnt_q  <= '0;
      score_inc_q <= 1'b0;
      score_clr_q <= 1'b0;
    end else begin
      score_inc_q <= score_inc_d;
      score_clr_q <= score_clr_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            state_q     <= S_COUNTDOWN;
            addr_q      <= '0;
            phase_q     <= '0;
            tick_cnt_q  <= '0;
            score_clr_q <= 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (bus.TICK) begin
            tick_cnt_q <= tick_cnt_q + 3'd1;
            if (tick_cnt_q == 3'd7) begin
              state_q    <= S_PLAY;
              tick_cnt_q <= '0;
            end
          end
        end
        S_PLAY: begin
          if (bus.TICK) phase_q <= phase_q + 2'd1;
`ifdef GH_LOOP_TRACK_EN
          if (load) addr_q <= addr_q + 7'd1;
          if (bus.PAUSE) state_q <= S_PAUSE;
`else
          if (load && (addr_q != 7'd127)) addr_q <= addr_q + 7'd1;
          // End of track wins over a simultaneous pause request; DRAIN ignores PAUSE.
          if (track_end) begin
            state_q    <= S_DRAIN;
            tick_cnt_q <= '0;
          end else if (bus.PAUSE) begin
            state_q <= S_PAUSE;
          end
`endif
        end
        S_PAUSE: begin
          if (!bus.PAUSE) state_q <= S_PLAY;
        end
        S_DRAIN: begin
          if (bus.TICK) begin
            tick_cnt_q <= tick_cnt_q + 3'd1;
            if (tick_cnt_q == 3'd7) begin
              state_q    <= S_DONE;
              tick_cnt_q <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.RAM_ADDR  = addr_q;
  assign bus.LOAD      = load;
  assign bus.SHIFT_EN  = judge_tick;
  assign bus.SCORE_INC = score_inc_q;
  assign bus.SCORE_CLR = score_clr_q;
  assign bus.GAME_OVER = (state_q == S_DONE);
  assign bus.STATE     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench for game_sequencer against a tick-counting
// reference model (play position tracked as total PLAY ticks).
module tb_game_sequencer;

  localparam int M_IDLE = 0, M_CD = 1, M_PLAY = 2, M_PAUSE = 3, M_DRAIN = 4, M_DONE = 5;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] addr;
    logic [4:0] strb; // LOAD, SHIFT_EN, SCORE_INC, SCORE_CLR, GAME_OVER
  } exp_t;

  logic clk;
  logic rst_n;
  game_sequencer_if bus ();

  game_sequencer dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_cd   = 0;  // countdown ticks seen
  int m_pt   = 0;  // PLAY ticks consumed since game start
  int m_dr   = 0;  // drain ticks seen
  bit m_inc  = 0;
  bit m_clr  = 0;
  bit prev_tick = 0;
  int pause_left = 0;
  int cyc = 0;

  function automatic int model_addr();
`ifdef GH_LOOP_TRACK_EN
    return (m_pt / 4) % 128;
`else
    return ((m_pt / 4) > 127) ? 127 : (m_pt / 4);
`endif
  endfunction

  task automatic step(input bit rst, input bit st, input bit ps, input bit tk,
                      input logic [3:0] note, input logic [3:0] keyn);
    exp_t e;
    bit   wrong;
    rst_n           = rst;
    bus.START       = st;
    bus.PAUSE       = ps;
    bus.TICK        = tk;
    bus.NOTE_BOTTOM = note;
    bus.KEY_N       = keyn;
    e.st   = 3'(m_mode);
    e.addr = 7'(model_addr());
    e.strb = {tk && (m_mode == M_PLAY) && ((m_pt % 4) == 3),
              tk && ((m_mode == M_PLAY) || (m_mode == M_DRAIN)),
              m_inc, m_clr, (m_mode == M_DONE)};
    sb_q.push_back(e);
    if (!rst) begin
      m_mode = M_IDLE; m_cd = 0; m_pt = 0; m_dr = 0; m_inc = 0; m_clr = 0;
    end else begin
      m_inc = 0; m_clr = 0;
      if (tk && ((m_mode == M_PLAY) || (m_mode == M_DRAIN))) begin
        wrong = 0;
        for (int unsigned i = 0; i < 4; i++)
          if ((keyn[i] == 1'b0) != note[i]) wrong = 1;
        m_clr = wrong;
        m_inc = !wrong && (note != 4'd0);
      end
      case (m_mode)
        M_IDLE, M_DONE: if (st) begin
          m_mode = M_CD; m_cd = 0; m_pt = 0; m_clr = 1;
        end
        M_CD: if (tk) begin
          m_cd++;
          if (m_cd == 8) m_mode = M_PLAY;
        end
        M_PLAY: begin
          if (tk) m_pt++;
`ifdef GH_LOOP_TRACK_EN
          if (ps) m_mode = M_PAUSE;
`else
          if (tk && (m_pt == 512)) begin
            m_mode = M_DRAIN; m_dr = 0;
          end else if (ps) m_mode = M_PAUSE;
`endif
        end
        M_PAUSE: if (!ps) m_mode = M_PLAY;
        M_DRAIN: if (tk) begin
          m_dr++;
          if (m_dr == 8) m_mode = M_DONE;
        end
        default: ;
      endcase
    end
    prev_tick = tk;
    cyc++;
    @(posedge clk);
    #2;
  endtask

  // Random cycle: one-wide ticks, notes biased so keys often match.
  task automatic rstep(input bit allow_pause, input bit st);
    bit tk;
    logic [3:0] note, keyn;
    bit ps;
    tk   = !prev_tick && ($urandom_range(0, 2) == 0);
    note = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    keyn = ($urandom_range(0, 1) == 0) ? ~note : 4'($urandom_range(0, 15));
    ps = 0;
    if (allow_pause) begin
      if (pause_left > 0) begin
        ps = 1; pause_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        pause_left = $urandom_range(1, 6);
      end
    end
    step(1'b1, st, ps, tk, note, keyn);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired after %0d cycles, model mode %0d required progress", name, cyc, m_mode);
  endtask

  // Monitor: pop one expected record per cycle and compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.STATE !== e.st) begin
          errors++;
          $display("FAIL state @%0t: got %0d expected %0d", $time, bus.STATE, e.st);
        end
        checks++;
        if (bus.RAM_ADDR !== e.addr) begin
          errors++;
          $display("FAIL ram_addr @%0t: got %0d expected %0d", $time, bus.RAM_ADDR, e.addr);
        end
        checks++;
        if ({bus.LOAD, bus.SHIFT_EN, bus.SCORE_INC, bus.SCORE_CLR, bus.GAME_OVER} !== e.strb) begin
          errors++;
          $display("FAIL strobes(ld,sh,inc,clr,go) @%0t: got %b expected %b", $time,
                   {bus.LOAD, bus.SHIFT_EN, bus.SCORE_INC, bus.SCORE_CLR, bus.GAME_OVER}, e.strb);
        end
      end
    end
  end

  logic [3:0] dir_note [3];
  logic [3:0] dir_key  [3];

  initial begin
    int n;
    dir_note[0] = 4'b0001; dir_key[0] = 4'b1110;
    dir_note[1] = 4'b0001; dir_key[1] = 4'b1111;
    dir_note[2] = 4'b0000; dir_key[2] = 4'b1111;

    rst_n = 1'b0; bus.START = 1'b0; bus.PAUSE = 1'b0; bus.TICK = 1'b0;
    bus.NOTE_BOTTOM = '0; bus.KEY_N = '1;
    repeat (2) @(posedge clk);
    #2;

    // Reset dominates active inputs.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);

    // Start, then countdown with stray START pulses.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
    n = 0;
    while (m_mode != M_PLAY && n < 200) begin rstep(1'b0, 1'($urandom_range(0, 1))); n++; end
    if (m_mode != M_PLAY) bound_fail("countdown");

    // Directed judging patterns, each on its own tick.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
      step(1'b1, 1'b0, 1'b0, 1'b1, dir_note[i], dir_key[i]);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);

    // Pause for 20 cycles with 5 ignored ticks, then resume.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 1'b1, (i % 4) == 2, 4'h1, 4'hF);
    for (int i = 0; i < 12; i++) rstep(1'b0, 1'b0);

    // Random play until address 37, then a one-cycle reset.
    n = 0;
    while (!(model_addr() == 37 && (m_mode == M_PLAY || m_mode == M_PAUSE)) && n < 3000) begin
      rstep(1'b1, 1'($urandom_range(0, 7) == 0)); n++;
    end
    if (model_addr() != 37) bound_fail("reach_addr37");
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'hA);
    // START held through reset release.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);

    // Full game to the end of the track.
    n = 0;
    while (m_mode != M_PLAY && n < 200) begin rstep(1'b0, 1'b0); n++; end
    if (m_mode != M_PLAY) bound_fail("countdown2");
`ifdef GH_LOOP_TRACK_EN
    n = 0;
    while (m_pt < 512 + 40 && n < 8000) begin rstep(1'b1, 1'($urandom_range(0, 7) == 0)); n++; end
    if (m_pt < 512 + 40) bound_fail("track_wrap");
`else
    n = 0;
    while (m_mode != M_DONE && n < 8000) begin rstep(1'b1, 1'($urandom_range(0, 7) == 0)); n++; end
    if (m_mode != M_DONE) bound_fail("track_done");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'(i % 2), 4'h2, 4'h0);
    // Restart from DONE.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
    for (int i = 0; i < 6; i++) rstep(1'b0, 1'b0);
`endif

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
